// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and NOP constant for pipeline stage registers
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} pipe_state_t;
  localparam logic [0:0] CTRL_NOP = '0;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one {valid, data, ctrl} holding register with load, clear and bubble masking
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 96,
  parameter int CTRL_W     = 8,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  // clear only drops valid/ctrl; data is kept so it can be shown on bubbles
  always_comb begin
    valid_d = clr_i ? 1'b0 : ld_i ? 1'b1 : valid_q;
    data_d  = (ld_i && !clr_i) ? data_i : data_q;
    ctrl_d  = clr_i ? {CTRL_W{CTRL_NOP}} : ld_i ? ctrl_i : ctrl_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= {CTRL_W{CTRL_NOP}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = (CLEAR_DATA && !valid_q) ? '0 : data_q;
  assign ctrl_o  = valid_q ? ctrl_q : {CTRL_W{CTRL_NOP}};
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready stage register with 2-entry skid, flush and bubble insertion
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 96,
  parameter int CTRL_W     = 8,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  pipe_state_t       state_q, state_d;
  logic              in_ready_q, acc, drn;
  logic              main_ld, main_clr, skid_ld, skid_clr, skid_valid;
  logic [DATA_W-1:0] skid_data, main_src_data;
  logic [CTRL_W-1:0] skid_ctrl, main_src_ctrl;
  assign acc = in_valid & in_ready_q & ~flush;
  assign drn = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= state_d != FULL;
    end
  end
  always_comb begin
    state_d  = state_q;
    main_ld  = 1'b0;
    main_clr = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    case (state_q)
      EMPTY: if (acc) begin
        state_d = BUSY;
        main_ld = 1'b1;
      end
      BUSY: if (acc && !drn) begin
        state_d = FULL;
        skid_ld = 1'b1;
      end else if (acc) begin
        main_ld = 1'b1;
      end else if (drn) begin
        state_d  = EMPTY;
        main_clr = 1'b1;
      end
      FULL: if (drn) begin
        state_d  = BUSY;
        main_ld  = 1'b1;
        skid_clr = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d  = EMPTY;
      main_ld  = 1'b0;
      skid_ld  = 1'b0;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end
  end
  // the skid only holds a beat in FULL, so it is the refill source whenever valid
  assign main_src_data = skid_valid ? skid_data : in_data;
  assign main_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;
  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .ld_i    (main_ld),
    .clr_i   (main_clr),
    .data_i  (main_src_data),
    .ctrl_i  (main_src_ctrl),
    .valid_o (out_valid),
    .data_o  (out_data),
    .ctrl_o  (out_ctrl)
  );
  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(1'b0)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .ld_i    (skid_ld),
    .clr_i   (skid_clr),
    .data_i  (in_data),
    .ctrl_i  (in_ctrl),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .ctrl_o  (skid_ctrl)
  );
  assign in_ready  = in_ready_q;
  assign occupancy = state_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: vector table, corner sequences and random run against a queue model
module tb_pipe_stage_skid;
  localparam int DW = 96;
  localparam int CW = 8;
  logic          clk = 1'b0, reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          in_ready0, in_ready1, out_valid0, out_valid1;
  logic [DW-1:0] out_data0, out_data1;
  logic [CW-1:0] out_ctrl0, out_ctrl1;
  logic [1:0]    occ0, occ1;
  always #5 clk = ~clk;
  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_ctrl(out_ctrl0), .occupancy(occ0));
  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_ctrl(out_ctrl1), .occupancy(occ1));
  typedef struct {logic [DW-1:0] d; logic [CW-1:0] c;} beat_t;
  typedef struct {
    logic rn, fl, iv, ordy; logic [15:0] d; logic [7:0] c;
    logic v; logic [15:0] ed; logic [7:0] ec; logic [1:0] eo; logic er;
  } vec_t;
  beat_t         q[$];
  logic          m_rdy = 1'b0;
  logic [DW-1:0] m_last = '0;
  int            n_chk = 0, n_err = 0;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  // reference: a FIFO of at most two beats; readiness is "room left after this edge"
  task automatic model_step();
    logic acc, drn;
    if (!reset_n) begin
      q.delete();
      m_rdy  = 1'b0;
      m_last = '0;
    end else begin
      acc = in_valid && m_rdy && !flush;
      drn = q.size() > 0 && out_ready;
      if (q.size() > 0) m_last = q[0].d;
      if (flush) q.delete();
      else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back('{in_data, in_ctrl});
      end
      m_rdy = q.size() < 2;
      if (q.size() > 0) m_last = q[0].d;
    end
  endtask
  task automatic check_model();
    beat_t hd;
    logic  v;
    v  = q.size() > 0;
    hd = '{'0, '0};
    if (v) hd = q[0];
    chk("m_valid0", DW'(out_valid0), DW'(v));
    chk("m_valid1", DW'(out_valid1), DW'(v));
    chk("m_data0", out_data0, v ? hd.d : m_last);
    chk("m_data1", out_data1, v ? hd.d : '0);
    chk("m_ctrl0", DW'(out_ctrl0), DW'(hd.c));
    chk("m_ctrl1", DW'(out_ctrl1), DW'(hd.c));
    chk("m_occ0", DW'(occ0), DW'(q.size()));
    chk("m_occ1", DW'(occ1), DW'(q.size()));
    chk("m_rdy0", DW'(in_ready0), DW'(m_rdy));
    chk("m_rdy1", DW'(in_ready1), DW'(m_rdy));
  endtask
  task automatic cyc(input logic rn, fl, iv, ordy, input logic [DW-1:0] d, input logic [CW-1:0] c);
    reset_n   = rn;
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    in_data   = d;
    in_ctrl   = c;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask
  vec_t          tbl[16];
  logic [DW-1:0] got[$];
  int            idx, maxocc;
  logic          ordy, take;
  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 2'd0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 8'h05, 1'b1, 16'h1234, 8'h05, 2'd1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 16'h1234, 8'h00, 2'd0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0011, 8'h01, 1'b1, 16'h0011, 8'h01, 2'd1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0022, 8'h02, 1'b1, 16'h0011, 8'h01, 2'd2, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h00AA, 8'h03, 1'b0, 16'h0011, 8'h00, 2'd0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 16'h0011, 8'h00, 2'd0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h00FF, 8'h04, 1'b1, 16'h00FF, 8'h04, 2'd1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 16'h00FF, 8'h00, 2'd0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0033, 8'h06, 1'b1, 16'h0033, 8'h06, 2'd1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0044, 8'h07, 1'b1, 16'h0033, 8'h06, 2'd2, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0055, 8'h00, 1'b0, 16'h0000, 8'h00, 2'd0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 2'd0, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0066, 8'h08, 1'b1, 16'h0066, 8'h08, 2'd1, 1'b1};
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rn, tbl[i].fl, tbl[i].iv, tbl[i].ordy, DW'(tbl[i].d), tbl[i].c);
      chk($sformatf("tbl%0d_valid", i), DW'(out_valid0), DW'(tbl[i].v));
      chk($sformatf("tbl%0d_data", i), out_data0, DW'(tbl[i].ed));
      chk($sformatf("tbl%0d_ctrl", i), DW'(out_ctrl0), DW'(tbl[i].ec));
      chk($sformatf("tbl%0d_occ", i), DW'(occ0), DW'(tbl[i].eo));
      chk($sformatf("tbl%0d_rdy", i), DW'(in_ready0), DW'(tbl[i].er));
      chk($sformatf("tbl%0d_clrdata", i), out_data1, tbl[i].v ? DW'(tbl[i].ed) : '0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b1, DW'(i), CW'(i + 1));
      chk($sformatf("stream%0d_data", i), out_data0, DW'(i));
      chk($sformatf("stream%0d_occ", i), DW'(occ0), DW'(1));
      chk($sformatf("stream%0d_rdy", i), DW'(in_ready0), DW'(1));
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    idx    = 0;
    maxocc = 0;
    for (int t = 0; t < 30 && got.size() < 8; t++) begin
      ordy = !(t >= 3 && t <= 6);
      take = idx < 8 && in_ready0;
      if (out_valid0 && ordy) got.push_back(out_data0);
      cyc(1'b1, 1'b0, idx < 8, ordy, DW'(100 + idx), CW'(idx + 1));
      if (take) idx++;
      if (int'(occ0) > maxocc) maxocc = int'(occ0);
    end
    chk("stall_count", DW'(got.size()), DW'(8));
    for (int k = 0; k < got.size() && k < 8; k++) chk($sformatf("stall_order%0d", k), got[k], DW'(100 + k));
    chk("stall_maxocc", DW'(maxocc), DW'(2));
    for (int t = 0; t < 3000; t++)
      cyc($urandom_range(0, 63) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) != 0, {$urandom, $urandom, $urandom}, CW'($urandom));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
